// File: rtl/status_monitor.sv
// Frame counter with heartbeat, blank-edge watchdog, and per-channel XERR sync/latch/stretch.
// Optional build macro STATUS_MONITOR_WDOG_EN enables the watchdog and status_orange.
module status_monitor #(
  parameter int unsigned COUNT_WIDTH    = 10,
  parameter int unsigned ERR_CH         = 2,
  parameter int unsigned STRETCH_CYCLES = 4096,
  parameter int unsigned WDOG_CYCLES    = 65536
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   led_blank,
  input  logic [ERR_CH-1:0]      led_xerr,
  input  logic                   err_clear,
  output logic [COUNT_WIDTH-1:0] frame_count,
  output logic [ERR_CH-1:0]      err_sticky,
  output logic                   status_yellow,
  output logic                   status_orange,
  output logic                   status_red
);

  localparam int unsigned StretchW = $clog2(STRETCH_CYCLES + 1);
  localparam logic [StretchW-1:0] StretchLoad = StretchW'(STRETCH_CYCLES);

  logic                   blank_prev_q;
  logic                   rise;
  logic [COUNT_WIDTH-1:0] frame_count_q, frame_count_d;
  logic [ERR_CH-1:0]      sync1_q, sync2_q;
  logic [ERR_CH-1:0]      err_s;
  logic [ERR_CH-1:0]      sticky_q, sticky_d;
  logic [StretchW-1:0]    stretch_q [ERR_CH];
  logic [StretchW-1:0]    stretch_d [ERR_CH];
  logic [ERR_CH-1:0]      stretched;

  assign rise  = led_blank & ~blank_prev_q;
  assign err_s = ~sync2_q;

  always_comb begin
    frame_count_d = frame_count_q;
    if (rise) begin
      frame_count_d = frame_count_q + 1'b1;
    end
  end

  // Set wins over clear so an error arriving with err_clear is never lost.
  assign sticky_d = (sticky_q & ~{ERR_CH{err_clear}}) | err_s;

  always_comb begin
    for (int i = 0; i < int'(ERR_CH); i++) begin
      stretch_d[i] = stretch_q[i];
      if (err_s[i]) begin
        stretch_d[i] = StretchLoad;
      end else if (stretch_q[i] != '0) begin
        stretch_d[i] = stretch_q[i] - 1'b1;
      end
      stretched[i] = (stretch_q[i] != '0);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      blank_prev_q  <= 1'b0;
      frame_count_q <= '0;
      sync1_q       <= '1;
      sync2_q       <= '1;
      sticky_q      <= '0;
      for (int i = 0; i < int'(ERR_CH); i++) begin
        stretch_q[i] <= '0;
      end
    end else begin
      blank_prev_q  <= led_blank;
      frame_count_q <= frame_count_d;
      sync1_q       <= led_xerr;
      sync2_q       <= sync1_q;
      sticky_q      <= sticky_d;
      for (int i = 0; i < int'(ERR_CH); i++) begin
        stretch_q[i] <= stretch_d[i];
      end
    end
  end

  assign frame_count   = frame_count_q;
  assign status_yellow = frame_count_q[COUNT_WIDTH-1];
  assign err_sticky    = sticky_q;
  assign status_red    = |stretched;

`ifdef STATUS_MONITOR_WDOG_EN
  localparam int unsigned WdogW = $clog2(WDOG_CYCLES);
  localparam logic [WdogW-1:0] WdogMax = WdogW'(WDOG_CYCLES - 1);

  logic [WdogW-1:0] wdog_q, wdog_d;
  logic             orange_q, orange_d;

  // A rise both restarts the count and clears the flag, even on the saturation cycle.
  always_comb begin
    wdog_d   = wdog_q;
    orange_d = orange_q;
    if (rise) begin
      wdog_d   = '0;
      orange_d = 1'b0;
    end else if (wdog_q == WdogMax) begin
      orange_d = 1'b1;
    end else begin
      wdog_d = wdog_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wdog_q   <= '0;
      orange_q <= 1'b0;
    end else begin
      wdog_q   <= wdog_d;
      orange_q <= orange_d;
    end
  end

  assign status_orange = orange_q;
`else
  // No watchdog built; the parameter is still referenced and the result is a constant 0.
  assign status_orange = 1'b0 && (WDOG_CYCLES != 0);
`endif

endmodule

// File: tb/tb_status_monitor.sv
// Self-checking bench for status_monitor: time-stamp based reference model plus directed
// and randomized scenarios. Watchdog expectations follow STATUS_MONITOR_WDOG_EN.
module tb_status_monitor;

  localparam int CW = 10;
  localparam int NCH = 2;
  localparam int STRETCH = 16;
  localparam int WDOG = 100;
`ifdef STATUS_MONITOR_WDOG_EN
  localparam bit WdogEn = 1'b1;
`else
  localparam bit WdogEn = 1'b0;
`endif

  logic           clock;
  logic           reset;
  logic           led_blank;
  logic [NCH-1:0] led_xerr;
  logic           err_clear;
  logic [CW-1:0]  frame_count;
  logic [NCH-1:0] err_sticky;
  logic           status_yellow;
  logic           status_orange;
  logic           status_red;

  status_monitor #(
    .COUNT_WIDTH   (CW),
    .ERR_CH        (NCH),
    .STRETCH_CYCLES(STRETCH),
    .WDOG_CYCLES   (WDOG)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .led_blank    (led_blank),
    .led_xerr     (led_xerr),
    .err_clear    (err_clear),
    .frame_count  (frame_count),
    .err_sticky   (err_sticky),
    .status_yellow(status_yellow),
    .status_orange(status_orange),
    .status_red   (status_red)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail = 0;

  // Reference model: edge index, time stamps of last error/rise, integer frame count.
  int             edge_n = 0;
  int             m_count = 0;
  logic [NCH-1:0] m_sticky = '0;
  int             last_err [NCH];
  int             last_rise = 0;
  logic           m_bprev = 1'b0;
  logic [NCH-1:0] xd1 = '1;
  logic [NCH-1:0] xd2 = '1;

  function automatic bit exp_red();
    for (int c = 0; c < NCH; c++) begin
      if (edge_n - last_err[c] < STRETCH) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic bit exp_orange();
    return WdogEn && (edge_n - last_rise >= WDOG);
  endfunction

  function automatic bit exp_yellow();
    return m_count >= (1 << (CW - 1));
  endfunction

  // One clock: capture driven inputs, advance the model at the edge, then settle 1 time unit.
  task automatic tick();
    logic           b, c, r;
    logic [NCH-1:0] x;
    logic [NCH-1:0] errs;
    b = led_blank; c = err_clear; r = reset; x = led_xerr;
    @(posedge clock);
    edge_n++;
    if (r) begin
      m_count = 0;
      m_sticky = '0;
      xd1 = '1;
      xd2 = '1;
      for (int k = 0; k < NCH; k++) last_err[k] = -1000000;
      last_rise = edge_n;
      m_bprev = 1'b0;
    end else begin
      errs = ~xd2;  // an XERR sample takes effect two edges after capture
      xd2 = xd1;
      xd1 = x;
      m_sticky = (c ? '0 : m_sticky) | errs;
      for (int k = 0; k < NCH; k++) if (errs[k]) last_err[k] = edge_n;
      if (b && !m_bprev) begin
        m_count = (m_count + 1) % (1 << CW);
        last_rise = edge_n;
      end
      m_bprev = b;
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; led_blank = 1'b0; led_xerr = '1; err_clear = 1'b0;
    tick(); tick();
    n_checks++;
    if (frame_count !== '0) begin
      n_fail++; $display("FAIL reset_count: got %0d want 0", frame_count);
    end
    n_checks++;
    if ({err_sticky, status_yellow, status_orange, status_red} !== '0) begin
      n_fail++;
      $display("FAIL reset_flags: sticky=%b y=%b o=%b r=%b want all 0", err_sticky,
               status_yellow, status_orange, status_red);
    end
    reset = 1'b0;
  endtask

  task automatic test_frames();
    for (int p = 0; p < 1024; p++) begin
      led_blank = 1'b1;
      for (int j = 0; j < 4; j++) tick();
      led_blank = 1'b0;
      for (int j = 0; j < 60; j++) tick();
      n_checks++;
      if (frame_count !== CW'(m_count)) begin
        n_fail++; $display("FAIL frame_count: pulse %0d got %0d want %0d", p, frame_count, m_count);
      end
      n_checks++;
      if (status_yellow !== exp_yellow()) begin
        n_fail++; $display("FAIL heartbeat: pulse %0d got %b want %b", p, status_yellow, exp_yellow());
      end
    end
    n_checks++;
    if (frame_count !== '0) begin
      n_fail++; $display("FAIL frame_wrap: got %0d want 0", frame_count);
    end
  endtask

  task automatic test_err_pulse();
    int first, high;
    first = -1; high = 0;
    led_xerr = 2'b01;
    tick();
    led_xerr = 2'b11;
    for (int j = 1; j <= 30; j++) begin
      tick();
      if (status_red === 1'b1) begin
        high++;
        if (first < 0) first = j;
      end
      n_checks++;
      if (status_red !== exp_red()) begin
        n_fail++; $display("FAIL red_pulse: cycle %0d got %b want %b", j, status_red, exp_red());
      end
    end
    n_checks++;
    if (first !== 2 || high !== STRETCH) begin
      n_fail++;
      $display("FAIL red_span: first=%0d len=%0d want first=2 len=%0d", first, high, STRETCH);
    end
    n_checks++;
    if (err_sticky !== 2'b10) begin
      n_fail++; $display("FAIL sticky_ch1: got %b want 10", err_sticky);
    end
  endtask

  task automatic test_sticky_clear();
    led_xerr = 2'b10;
    tick();
    led_xerr = 2'b11;
    tick();
    err_clear = 1'b1;  // coincides with the channel-0 error reaching the sticky bit
    tick();
    err_clear = 1'b0;
    n_checks++;
    if (err_sticky !== 2'b01 || err_sticky !== m_sticky) begin
      n_fail++; $display("FAIL set_beats_clear: got %b want 01 (model %b)", err_sticky, m_sticky);
    end
    for (int j = 0; j < 3; j++) tick();
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    n_checks++;
    if (err_sticky !== 2'b00) begin
      n_fail++; $display("FAIL sticky_clear: got %b want 00", err_sticky);
    end
  endtask

  task automatic test_watchdog();
    int first;
    first = -1;
    led_blank = 1'b1;
    tick();
    led_blank = 1'b0;
    for (int j = 1; j <= WDOG + 5; j++) begin
      tick();
      if (status_orange === 1'b1 && first < 0) first = j;
      n_checks++;
      if (status_orange !== exp_orange()) begin
        n_fail++; $display("FAIL wdog_run: cycle %0d got %b want %b", j, status_orange, exp_orange());
      end
    end
    n_checks++;
    if (first !== (WdogEn ? WDOG : -1)) begin
      n_fail++; $display("FAIL wdog_onset: got %0d want %0d", first, WdogEn ? WDOG : -1);
    end
    led_blank = 1'b1;
    tick();
    led_blank = 1'b0;
    n_checks++;
    if (status_orange !== 1'b0) begin
      n_fail++; $display("FAIL wdog_clear: got %b want 0", status_orange);
    end
    for (int j = 1; j < WDOG; j++) tick();
    led_blank = 1'b1;  // rise lands on the saturation cycle
    tick();
    led_blank = 1'b0;
    for (int j = 0; j < 5; j++) begin
      n_checks++;
      if (status_orange !== 1'b0 || status_orange !== exp_orange()) begin
        n_fail++; $display("FAIL wdog_sat_rise: step %0d got %b want 0", j, status_orange);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    reset = 1'b1; tick(); reset = 1'b0;
    for (int p = 0; p < 37; p++) begin
      led_blank = 1'b1; tick(); led_blank = 1'b0; tick();
    end
    n_checks++;
    if (frame_count !== 10'd37) begin
      n_fail++; $display("FAIL pre_reset_count: got %0d want 37", frame_count);
    end
    for (int j = 0; j < 95; j++) tick();
    led_xerr = 2'b10; tick(); led_xerr = 2'b11;
    for (int j = 0; j < 4; j++) tick();
    n_checks++;
    if (status_red !== 1'b1 || status_orange !== WdogEn) begin
      n_fail++; $display("FAIL pre_reset_state: red=%b orange=%b want 1/%b", status_red,
                         status_orange, WdogEn);
    end
    reset = 1'b1; tick(); reset = 1'b0;
    n_checks++;
    if ({frame_count, err_sticky, status_yellow, status_orange, status_red} !== '0) begin
      n_fail++;
      $display("FAIL mid_reset: cnt=%0d sticky=%b y=%b o=%b r=%b want all 0", frame_count,
               err_sticky, status_yellow, status_orange, status_red);
    end
    for (int p = 0; p < 5; p++) begin
      led_blank = 1'b1; tick(); led_blank = 1'b0; tick();
      n_checks++;
      if (frame_count !== CW'(p + 1) || status_red !== 1'b0 || err_sticky !== '0) begin
        n_fail++; $display("FAIL resume: got cnt=%0d red=%b sticky=%b want %0d/0/00", frame_count,
                           status_red, err_sticky, p + 1);
      end
    end
  endtask

  task automatic test_idle_long();
    led_blank = 1'b0;
    for (int j = 0; j < 10 * WDOG; j++) begin
      tick();
      n_checks++;
      if (status_orange !== exp_orange()) begin
        n_fail++; $display("FAIL idle_orange: cycle %0d got %b want %b", j, status_orange,
                           exp_orange());
      end
    end
  endtask

  task automatic test_random();
    for (int j = 0; j < 3000; j++) begin
      if ($urandom_range(0, 99) < 2) led_blank = ~led_blank;
      for (int c = 0; c < NCH; c++) led_xerr[c] = ($urandom_range(0, 63) != 0);
      err_clear = ($urandom_range(0, 31) == 0);
      reset = ($urandom_range(0, 999) == 0);
      tick();
      n_checks++;
      if (frame_count !== CW'(m_count) || err_sticky !== m_sticky) begin
        n_fail++; $display("FAIL rnd_state: cycle %0d cnt=%0d sticky=%b want %0d/%b", j,
                           frame_count, err_sticky, m_count, m_sticky);
      end
      n_checks++;
      if (status_red !== exp_red() || status_orange !== exp_orange() ||
          status_yellow !== exp_yellow()) begin
        n_fail++; $display("FAIL rnd_leds: cycle %0d ryo=%b%b%b want %b%b%b", j, status_red,
                           status_yellow, status_orange, exp_red(), exp_yellow(), exp_orange());
      end
    end
    reset = 1'b0; err_clear = 1'b0; led_xerr = '1; led_blank = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < NCH; k++) last_err[k] = -1000000;
    test_reset();
    test_frames();
    test_err_pulse();
    test_sticky_clear();
    test_watchdog();
    test_reset_mid();
    test_idle_long();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/status_monitor.md
# status_monitor

Board status monitor for the LED panel driver. Counts frames via rising edges of the driver's blank strobe, drives a heartbeat LED, and flags a stalled driver with a frame watchdog. Synchronises, latches and pulse-stretches a parametrised number of active-low XERR inputs. Sits beside `pixeldriver` in the top level and drives the yellow, orange and red status LEDs.

## Interface
Parameters:
- `COUNT_WIDTH`, 10: width of the frame counter; its MSB is the heartbeat.
- `ERR_CH`, 2: number of independent active-low XERR inputs.
- `STRETCH_CYCLES`, 4096: minimum clock cycles the red LED stays lit after an error sample; must be ≥1.
- `WDOG_CYCLES`, 65536: clock cycles without a blank rising edge before stall is flagged; must be ≥2.

Ports:
- `clock`  in  1  system clock; every register is on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `led_blank`  in  1  blank strobe from `pixeldriver`; same clock domain, not synchronised.
- `led_xerr`  in  ERR_CH  active-low error flags; asynchronous, synchronised internally.
- `err_clear`  in  1  single-cycle request to clear `err_sticky`.
- `frame_count`  out  COUNT_WIDTH  count of blank rising edges, wraps.
- `err_sticky`  out  ERR_CH  per-channel latched error.
- `status_yellow`  out  1  heartbeat, `frame_count[COUNT_WIDTH-1]`.
- `status_orange`  out  1  watchdog stall flag.
- `status_red`  out  1  OR of all per-channel stretched errors.

## Operation
- Reset values: `frame_count`=0, `err_sticky`=0, all LEDs 0, blank-previous register=0, sync flops=1 (no error), stretch counters=0, watchdog counter=0.
- Edge detect: rise = `led_blank` & !blank_prev. blank_prev <= `led_blank` every cycle.
- Frame counter: +1 on rise, modulo 2^COUNT_WIDTH (all-ones wraps to 0, no flag).
- XERR path per channel: 2-flop synchroniser → err_s (1 = error, i.e. inverted sync output).
- Stretch counter per channel, width clog2(STRETCH_CYCLES+1): err_s=1 → load STRETCH_CYCLES; otherwise decrement while nonzero, hold at 0. Stretched = counter≠0. A continuously asserted error keeps reloading, so red stays lit for the whole error plus STRETCH_CYCLES.
- Sticky: err_s=1 sets the bit. `err_clear` clears all bits not set in the same cycle; set wins over clear.
- Watchdog: counter resets to 0 on rise. Otherwise it increments and saturates at WDOG_CYCLES-1. `status_orange` is registered: it sets when the counter is WDOG_CYCLES-1 and there is no rise, and clears on the cycle following a rise. Rise and saturation in the same cycle: rise wins.
- Reset mid-operation returns every state element to its reset value on that edge; partial stretch or watchdog progress is discarded.

## Timing
- Rise sampled at edge N: `frame_count` updates after edge N; `status_yellow` follows in the same cycle.
- XERR falling before edge k: sync1 at k, sync2 at k+1, stretch/sticky update at k+2. `status_red` and `err_sticky` are high after edge k+2.
- After XERR deasserts, `status_red` falls exactly STRETCH_CYCLES cycles after the last cycle in which err_s=1, provided no other channel is stretched.
- With no rise after edge R, `status_orange` rises after edge R+WDOG_CYCLES. It falls one edge after the next rise.
- All outputs are registered or are direct bits of registers, except `status_red`, which is an OR of registered comparisons.

## Configuration
- `STATUS_MONITOR_WDOG_EN`: when defined, the watchdog counter and `status_orange` logic are built as specified.
- When undefined, no watchdog register exists and `status_orange` is tied to 0. All other behaviour is unchanged.

## Test plan
- Reset, then 1024 blank pulses (4 high / 60 low cycles), defaults → `frame_count` goes 0→1023 then wraps to 0. `status_yellow` is high from count 512 to 1023.
- `led_xerr[1]` low for 1 cycle, STRETCH_CYCLES=16 → `status_red` is high after edge k+2 for exactly 16 cycles. `err_sticky`=2'b10 and stays set. Channel 0 is unaffected.
- `err_clear` pulsed in the same cycle as a new err_s on channel 0 → `err_sticky[0]` stays 1. A later `err_clear` with no error → 0.
- WDOG_CYCLES=100, blank held low after one rise → `status_orange` rises 100 edges after the rise. The next rise clears it one edge later. A rise on the saturation cycle → no assertion.
- Assert `reset` mid-stretch with a saturated watchdog and `frame_count`=37 → all outputs are 0 on the next edge. Outputs resume correctly afterwards.
- Build without `STATUS_MONITOR_WDOG_EN`, blank idle for 10×WDOG_CYCLES → `status_orange` stays 0. All other scenarios still pass.
